// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS wave-generator slice: default tuning-word and
// dwell widths, sweep mode codes, sweep FSM state encoding and a small mode
// decode helper. Used by the sweep controller, the phase accumulator and the
// wave modules.
// -----------------------------------------------------------------------------
package dds_pkg;

   localparam int DDS_PHASE_W = 32;
   localparam int DDS_DWELL_W = 20;

   // Sweep modes; code 3 behaves as a single sweep.
   localparam logic [1:0] MODE_SINGLE = 2'd0;
   localparam logic [1:0] MODE_REPEAT = 2'd1;
   localparam logic [1:0] MODE_UPDOWN = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SWEEP  = 2'd1,
      ST_FINISH = 2'd2
   } sweep_state_e;

   // True for every mode that ends after one pass (0 and the spare code 3).
   function automatic logic mode_is_single(input logic [1:0] mode);
      logic res;
      case (mode)
         MODE_REPEAT: res = 1'b0;
         MODE_UPDOWN: res = 1'b0;
         default:     res = 1'b1;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl_if
// Control/status bundle between a sweep requester and the sweep controller.
//   start/abort       : request strobes (abort wins)
//   mode              : sweep mode code
//   f_start/f_stop    : first / last tuning word
//   f_step            : unsigned step magnitude
//   dwell             : cycles per point (0 behaves as 1)
//   tune_word/_valid  : registered tuning word and its load pulse
//   busy/done         : sweep activity and single-sweep completion pulse
// master = requester, slave = sweep controller.
// -----------------------------------------------------------------------------
interface dds_sweep_ctrl_if
   import dds_pkg::*;
#(
   parameter int PHASE_W = DDS_PHASE_W,
   parameter int DWELL_W = DDS_DWELL_W
);

   logic               start;
   logic               abort;
   logic [1:0]         mode;
   logic [PHASE_W-1:0] f_start;
   logic [PHASE_W-1:0] f_stop;
   logic [PHASE_W-1:0] f_step;
   logic [DWELL_W-1:0] dwell;
   logic [PHASE_W-1:0] tune_word;
   logic               tune_valid;
   logic               busy;
   logic               done;

   modport master (
      output start, abort, mode, f_start, f_stop, f_step, dwell,
      input  tune_word, tune_valid, busy, done
   );

   modport slave (
      input  start, abort, mode, f_start, f_stop, f_step, dwell,
      output tune_word, tune_valid, busy, done
   );

endinterface

// File: rtl/dds_step_calc.sv
// -----------------------------------------------------------------------------
// dds_step_calc
// Combinational next-point calculator for the frequency sweep.
//   tune_word       in  : current tuning word
//   f_step          in  : step magnitude
//   f_start/f_stop  in  : latched sweep endpoints
//   dir             in  : current direction (1 = up)
//   init_dir        in  : direction of the first pass (1 = up)
//   next_word       out : next point in the current direction, clamped
//   rev_word        out : next point after a direction reversal, clamped
//   at_endpoint     out : current word equals the endpoint being approached
// -----------------------------------------------------------------------------
module dds_step_calc
   import dds_pkg::*;
#(
   parameter int PHASE_W = DDS_PHASE_W
) (
   input  logic [PHASE_W-1:0] tune_word,
   input  logic [PHASE_W-1:0] f_step,
   input  logic [PHASE_W-1:0] f_start,
   input  logic [PHASE_W-1:0] f_stop,
   input  logic               dir,
   input  logic               init_dir,
   output logic [PHASE_W-1:0] next_word,
   output logic [PHASE_W-1:0] rev_word,
   output logic               at_endpoint
);

   // One step toward target; the extra bit catches wrap past 0 / max, and both
   // wrap and overshoot land exactly on the target.
   function automatic logic [PHASE_W-1:0] step_toward(
      input logic [PHASE_W-1:0] cur,
      input logic [PHASE_W-1:0] step,
      input logic [PHASE_W-1:0] target,
      input logic               up
   );
      logic [PHASE_W:0]   ext;
      logic [PHASE_W-1:0] res;
      if (up) begin
         ext = {1'b0, cur} + {1'b0, step};
         if (ext[PHASE_W] || (ext[PHASE_W-1:0] > target)) res = target;
         else                                             res = ext[PHASE_W-1:0];
      end else begin
         ext = {1'b0, cur} - {1'b0, step};
         if (ext[PHASE_W] || (ext[PHASE_W-1:0] < target)) res = target;
         else                                             res = ext[PHASE_W-1:0];
      end
      return res;
   endfunction

   logic               fwd_pass_s;
   logic [PHASE_W-1:0] fwd_target_s;
   logic [PHASE_W-1:0] rev_target_s;

   // Moving in the first-pass direction heads for f_stop, otherwise for f_start.
   assign fwd_pass_s   = (dir == init_dir);
   assign fwd_target_s = fwd_pass_s ? f_stop  : f_start;
   assign rev_target_s = fwd_pass_s ? f_start : f_stop;

   assign next_word    = step_toward(tune_word, f_step, fwd_target_s, dir);
   assign rev_word     = step_toward(tune_word, f_step, rev_target_s, ~dir);
   assign at_endpoint  = (tune_word == fwd_target_s);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
// Frequency-sweep scheduler: steps a DDS tuning word from f_start to f_stop in
// f_step increments, holding each point for max(dwell,1) cycles. Supports
// single, repeating (sawtooth) and up/down (triangle) sweeps.
//   clk_in  in : system clock
//   rst     in : synchronous active-high reset
//   bus        : dds_sweep_ctrl_if.slave (requests/config in, tuning word and
//                status out; all outputs registered)
// -----------------------------------------------------------------------------
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int PHASE_W = DDS_PHASE_W,
   parameter int DWELL_W = DDS_DWELL_W
) (
   input  logic             clk_in,
   input  logic             rst,
   dds_sweep_ctrl_if.slave  bus
);

   localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
   localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
   localparam logic [PHASE_W-1:0] WORD_ZERO  = {PHASE_W{1'b0}};

   sweep_state_e       state_r;
   logic [1:0]         mode_r;
   logic [PHASE_W-1:0] f_start_r;
   logic [PHASE_W-1:0] f_stop_r;
   logic [PHASE_W-1:0] f_step_r;
   logic [DWELL_W-1:0] dwell_r;
   logic [DWELL_W-1:0] dwell_cnt_r;
   logic               dir_r;
   logic               init_dir_r;
   logic               degen_r;
   logic [PHASE_W-1:0] tune_word_r;
   logic               tune_valid_r;
   logic               busy_r;
   logic               done_r;

   logic [PHASE_W-1:0] next_word_s;
   logic [PHASE_W-1:0] rev_word_s;
   logic               at_endpoint_s;

   dds_step_calc #(.PHASE_W(PHASE_W)) u_step_calc (
      .tune_word   (tune_word_r),
      .f_step      (f_step_r),
      .f_start     (f_start_r),
      .f_stop      (f_stop_r),
      .dir         (dir_r),
      .init_dir    (init_dir_r),
      .next_word   (next_word_s),
      .rev_word    (rev_word_s),
      .at_endpoint (at_endpoint_s)
   );

   // Sweep FSM, config latch, dwell counter and registered outputs.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         mode_r       <= MODE_SINGLE;
         f_start_r    <= WORD_ZERO;
         f_stop_r     <= WORD_ZERO;
         f_step_r     <= WORD_ZERO;
         dwell_r      <= DWELL_ZERO;
         dwell_cnt_r  <= DWELL_ZERO;
         dir_r        <= 1'b1;
         init_dir_r   <= 1'b1;
         degen_r      <= 1'b0;
         tune_word_r  <= WORD_ZERO;
         tune_valid_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         // Strobes default low; only load/finish edges raise them.
         tune_valid_r <= 1'b0;
         done_r       <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start && !bus.abort) begin
                  mode_r       <= bus.mode;
                  f_start_r    <= bus.f_start;
                  f_stop_r     <= bus.f_stop;
                  f_step_r     <= bus.f_step;
                  dwell_r      <= (bus.dwell == DWELL_ZERO) ? DWELL_ONE : bus.dwell;
                  dwell_cnt_r  <= (bus.dwell == DWELL_ZERO) ? DWELL_ONE : bus.dwell;
                  dir_r        <= (bus.f_stop >= bus.f_start);
                  init_dir_r   <= (bus.f_stop >= bus.f_start);
                  // A zero step or coincident endpoints collapse to one point.
                  degen_r      <= (bus.f_start == bus.f_stop) || (bus.f_step == WORD_ZERO);
                  tune_word_r  <= bus.f_start;
                  tune_valid_r <= 1'b1;
                  busy_r       <= 1'b1;
                  state_r      <= ST_SWEEP;
               end
            end

            ST_SWEEP: begin
               if (bus.abort) begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else if (dwell_cnt_r <= DWELL_ONE) begin
                  dwell_cnt_r <= dwell_r;
                  if (degen_r) begin
                     // Single point: one-shot modes finish, others hold silently.
                     if (mode_is_single(mode_r)) begin
                        done_r  <= 1'b1;
                        state_r <= ST_FINISH;
                     end
                  end else if (at_endpoint_s) begin
                     case (mode_r)
                        MODE_REPEAT: begin
                           tune_word_r  <= f_start_r;
                           tune_valid_r <= 1'b1;
                        end
                        MODE_UPDOWN: begin
                           dir_r        <= ~dir_r;
                           tune_word_r  <= rev_word_s;
                           tune_valid_r <= 1'b1;
                        end
                        default: begin
                           done_r  <= 1'b1;
                           state_r <= ST_FINISH;
                        end
                     endcase
                  end else begin
                     tune_word_r  <= next_word_s;
                     tune_valid_r <= 1'b1;
                  end
               end else begin
                  dwell_cnt_r <= dwell_cnt_r - DWELL_ONE;
               end
            end

            ST_FINISH: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end

            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.tune_word  = tune_word_r;
   assign bus.tune_valid = tune_valid_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
module tb_dds_sweep_ctrl;
   import dds_pkg::*;

   localparam int PW = 32;
   localparam int DW = 20;

   logic clk_in = 1'b0;
   logic rst;

   always #5 clk_in = ~clk_in;

   dds_sweep_ctrl_if #(.PHASE_W(PW), .DWELL_W(DW)) bus ();

   dds_sweep_ctrl #(.PHASE_W(PW), .DWELL_W(DW)) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .bus    (bus)
   );

   typedef struct packed {
      logic [PW-1:0] word;
      logic          valid;
      logic          busy;
      logic          done;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [PW-1:0] w, input logic v, input logic b, input logic d);
      exp_t e;
      e.word = w; e.valid = v; e.busy = b; e.done = d;
      exp_q.push_back(e);
   endtask

   // One frequency point held for n cycles, load pulse on its first cycle.
   task automatic push_pt(input logic [PW-1:0] w, input int n);
      push(w, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i < n; i++) push(w, 1'b0, 1'b1, 1'b0);
   endtask

   // Completion: done pulse with busy still high, then idle.
   task automatic push_end(input logic [PW-1:0] w);
      push(w, 1'b0, 1'b1, 1'b1);
      push(w, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic cycle(input string tag);
      exp_t e;
      @(posedge clk_in);
      #1;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s.queue observed=empty expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, ".word"},  bus.tune_word,            e.word);
         chk({tag, ".valid"}, {31'd0, bus.tune_valid},  {31'd0, e.valid});
         chk({tag, ".busy"},  {31'd0, bus.busy},        {31'd0, e.busy});
         chk({tag, ".done"},  {31'd0, bus.done},        {31'd0, e.done});
      end
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag);
   endtask

   task automatic cfg(input logic [1:0] m, input logic [PW-1:0] fs, input logic [PW-1:0] fe,
                      input logic [PW-1:0] st, input logic [DW-1:0] dw);
      bus.mode = m; bus.f_start = fs; bus.f_stop = fe; bus.f_step = st; bus.dwell = dw;
   endtask

   task automatic go(input string tag);
      bus.start = 1'b1;
      cycle(tag);
      bus.start = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      cfg(MODE_SINGLE, 32'd0, 32'd0, 32'd0, 20'd0);

      // Reset state
      push(32'd0, 1'b0, 1'b0, 1'b0); cycle("reset");
      push(32'd0, 1'b0, 1'b0, 1'b0); cycle("reset");
      rst = 1'b0;
      push(32'd0, 1'b0, 1'b0, 1'b0); cycle("idle");

      // Single up sweep, dwell 3: busy spans 13 cycles
      cfg(MODE_SINGLE, 32'd100, 32'd400, 32'd100, 20'd3);
      push_pt(32'd100, 3); push_pt(32'd200, 3); push_pt(32'd300, 3); push_pt(32'd400, 3);
      push_end(32'd400);
      go("t1"); run("t1", 13);

      // Single down sweep with clamp to 50; dwell 0 behaves as 1
      cfg(MODE_SINGLE, 32'd400, 32'd50, 32'd100, 20'd0);
      push_pt(32'd400, 1); push_pt(32'd300, 1); push_pt(32'd200, 1);
      push_pt(32'd100, 1); push_pt(32'd50, 1);
      push_end(32'd50);
      go("t2"); run("t2", 6);

      // Triangle 0..200, never done; abort holds the last word
      cfg(MODE_UPDOWN, 32'd0, 32'd200, 32'd100, 20'd1);
      push_pt(32'd0, 1);   push_pt(32'd100, 1); push_pt(32'd200, 1); push_pt(32'd100, 1);
      push_pt(32'd0, 1);   push_pt(32'd100, 1); push_pt(32'd200, 1); push_pt(32'd100, 1);
      go("t3"); run("t3", 7);
      bus.abort = 1'b1;
      push(32'd100, 1'b0, 1'b0, 1'b0); cycle("t3_abort");
      bus.abort = 1'b0;

      // Repeating sawtooth 10..30 dwell 2, abort after 7 cycles
      cfg(MODE_REPEAT, 32'd10, 32'd30, 32'd10, 20'd2);
      push_pt(32'd10, 2); push_pt(32'd20, 2); push_pt(32'd30, 2); push_pt(32'd10, 1);
      go("t4"); run("t4", 6);
      bus.abort = 1'b1;
      push(32'd10, 1'b0, 1'b0, 1'b0); cycle("t4_abort");
      bus.abort = 1'b0;
      push(32'd10, 1'b0, 1'b0, 1'b0); cycle("t4_idle");

      // Single point near the top of the range: no wrap
      cfg(MODE_SINGLE, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h0000_0020, 20'd3);
      push_pt(32'hFFFF_FFF0, 3);
      push_end(32'hFFFF_FFF0);
      go("t5"); run("t5", 4);

      // start and abort together: nothing starts
      cfg(MODE_SINGLE, 32'd100, 32'd400, 32'd100, 20'd3);
      bus.abort = 1'b1;
      bus.start = 1'b1;
      push(32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0); cycle("t6_startabort");
      bus.start = 1'b0;
      bus.abort = 1'b0;
      push(32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0); cycle("t6_startabort_idle");

      // start while busy with new config is ignored; rst mid-sweep clears all
      push_pt(32'd100, 3); push_pt(32'd200, 3);
      go("t6_busy"); run("t6_busy", 1);
      cfg(MODE_UPDOWN, 32'd7, 32'd9, 32'd1, 20'd1);
      bus.start = 1'b1;
      run("t6_busy", 2);
      bus.start = 1'b0;
      run("t6_busy", 2);
      rst = 1'b1;
      push(32'd0, 1'b0, 1'b0, 1'b0); cycle("t6_rst");
      rst = 1'b0;
      push(32'd0, 1'b0, 1'b0, 1'b0); cycle("t6_rst_idle");

      // Zero step in repeat mode: holds f_start, single load pulse
      cfg(MODE_REPEAT, 32'd55, 32'd99, 32'd0, 20'd0);
      push_pt(32'd55, 6);
      go("t7"); run("t7", 5);
      bus.abort = 1'b1;
      push(32'd55, 1'b0, 1'b0, 1'b0); cycle("t7_abort");
      bus.abort = 1'b0;

      // Every expected entry must have been consumed
      n_tests++;
      assert (exp_q.size() == 0)
      else begin
         n_fail++;
         $error("FAIL drain observed=%0d expected=0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
